// File: rtl/prog_loader.sv
// prog_loader
// Byte-stream program loader. Accepts a framed program image over a
// valid/ready byte stream and writes the payload into the 4096x8 program
// memory starting at BASE_ADDR. The CPU is held in reset while a frame is
// in progress, and sticky status flags report the outcome.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, LEN data bytes, CSUM (mod-256 data sum)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    stream byte
//   in_valid   in_data valid this cycle
//   in_ready   loader can accept a byte (always 1 out of reset)
//   mem_addr   memory write address (holds when mem_we=0)
//   mem_wdata  memory write data (holds when mem_we=0)
//   mem_we     one-cycle write strobe per data byte
//   cpu_hold   CPU held in reset while a frame is in progress
//   load_done  sticky: last frame completed with good checksum
//   load_err   sticky: last frame rejected (bad length or checksum)
module prog_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h200,
  parameter logic [7:0]  SYNC_BYTE = 8'h4C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM
  } state_t;

  // Largest payload that fits between BASE_ADDR and the top of memory.
  localparam logic [16:0] MAX_LEN = 17'h1000 - {5'd0, BASE_ADDR};

  state_t      state_q, state_d;
  logic [7:0]  lenHi_q, lenHi_d;
  logic [12:0] cnt_q, cnt_d;
  logic [11:0] ptr_q, ptr_d;
  logic [7:0]  csum_q, csum_d;
  logic [11:0] memAddr_q, memAddr_d;
  logic [7:0]  memWdata_q, memWdata_d;
  logic        memWe_q, memWe_d;
  logic        cpuHold_q, cpuHold_d;
  logic        loadDone_q, loadDone_d;
  logic        loadErr_q, loadErr_d;

  logic        accept;
  logic [15:0] lenFull;
  logic        lenBad;

  // The loader never stalls; it is only unready while reset is held.
  assign in_ready = ~rst;
  assign accept   = in_valid & in_ready;

  // Length is complete once the low byte arrives on the stream.
  assign lenFull = {lenHi_q, in_data};
  assign lenBad  = (lenFull == 16'd0) || ({1'b0, lenFull} > MAX_LEN);

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lenHi_q    <= 8'd0;
      cnt_q      <= 13'd0;
      ptr_q      <= 12'd0;
      csum_q     <= 8'd0;
      memAddr_q  <= 12'd0;
      memWdata_q <= 8'd0;
      memWe_q    <= 1'b0;
      cpuHold_q  <= 1'b0;
      loadDone_q <= 1'b0;
      loadErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lenHi_q    <= lenHi_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      csum_q     <= csum_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      cpuHold_q  <= cpuHold_d;
      loadDone_q <= loadDone_d;
      loadErr_q  <= loadErr_d;
    end
  end

  // Next-state logic: the FSM only moves on an accepted byte.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        IDLE:    if (in_data == SYNC_BYTE) state_d = LEN_HI;
        LEN_HI:  state_d = LEN_LO;
        LEN_LO:  state_d = lenBad ? IDLE : DATA;
        DATA:    if (cnt_q == 13'd1) state_d = CSUM;
        CSUM:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values. Write address/data hold between
  // strobes, so they are only updated when a data byte is accepted.
  always_comb begin
    lenHi_d    = lenHi_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    csum_d     = csum_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = 1'b0;
    cpuHold_d  = cpuHold_q;
    loadDone_d = loadDone_q;
    loadErr_d  = loadErr_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (in_data == SYNC_BYTE) begin
            cpuHold_d  = 1'b1;
            loadDone_d = 1'b0;
            loadErr_d  = 1'b0;
            csum_d     = 8'd0;
          end
        end
        LEN_HI: lenHi_d = in_data;
        LEN_LO: begin
          if (lenBad) begin
            loadErr_d = 1'b1;
            cpuHold_d = 1'b0;
          end else begin
            ptr_d = BASE_ADDR;
            cnt_d = lenFull[12:0];
          end
        end
        DATA: begin
          memWe_d    = 1'b1;
          memAddr_d  = ptr_q;
          memWdata_d = in_data;
          csum_d     = csum_q + in_data;
          ptr_d      = ptr_q + 12'd1;
          cnt_d      = cnt_q - 13'd1;
        end
        CSUM: begin
          if (in_data == csum_q) loadDone_d = 1'b1;
          else                   loadErr_d  = 1'b1;
          cpuHold_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_we    = memWe_q;
  assign cpu_hold  = cpuHold_q;
  assign load_done = loadDone_q;
  assign load_err  = loadErr_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. Byte streams are interpreted by a
// frame-parsing reference model; observed memory writes are collected by a
// monitor and compared against the model's expected writes and status.
module tb_prog_loader;

  localparam int         BASE = 'h200;
  localparam logic [7:0] SYNC = 8'h4C;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim[$];
  logic [19:0] expQ[$];
  logic [19:0] gotQ[$];
  int          gotCyc[$];
  logic        expDone = 1'b0;
  logic        expErr  = 1'b0;
  logic        expHold = 1'b0;

  int   cycle = 0;
  int   lastWeCyc = -1;
  int   holdFallCyc = -1;
  logic prevHold = 1'b0;

  prog_loader dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: collect writes and the cpu_hold falling edge mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      gotQ.push_back({mem_addr, mem_wdata});
      gotCyc.push_back(cycle);
      lastWeCyc = cycle;
    end
    if (prevHold === 1'b1 && cpu_hold === 1'b0) holdFallCyc = cycle;
    prevHold = cpu_hold;
  end

  // Reference model: parse the byte list as frames and list the writes
  // and final status a correct loader would produce.
  function automatic void modelStream();
    int i = 0;
    int n = stim.size();
    int len;
    logic [7:0] sum;
    expQ.delete();
    while (i < n) begin
      if (stim[i] !== SYNC) begin
        i++;
        continue;
      end
      expDone = 1'b0;
      expErr  = 1'b0;
      expHold = 1'b1;
      if (i + 2 >= n) break;
      len = int'(stim[i+1]) * 256 + int'(stim[i+2]);
      i += 3;
      if (len == 0 || len > 4096 - BASE) begin
        expErr  = 1'b1;
        expHold = 1'b0;
        continue;
      end
      sum = 8'd0;
      for (int k = 0; k < len && i < n; k++) begin
        expQ.push_back({12'(BASE + k), stim[i]});
        sum = sum + stim[i];
        i++;
      end
      if (i >= n) break;
      if (stim[i] == sum) expDone = 1'b1;
      else                expErr  = 1'b1;
      expHold = 1'b0;
      i++;
    end
  endfunction

  task automatic applyFrame(input int len, input logic goodSum, input logic forceSync);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    stim.push_back(SYNC);
    stim.push_back(8'(len >> 8));
    stim.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = (forceSync && k == len / 2) ? SYNC : 8'($urandom);
      stim.push_back(b);
      sum = sum + b;
    end
    stim.push_back(goodSum ? sum : sum ^ 8'h5A);
  endtask

  task automatic applyStimulus(input int gapMax);
    int g;
    gotQ.delete();
    gotCyc.delete();
    for (int i = 0; i < stim.size(); i++) begin
      g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stim[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !== 25'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err});
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset got=%b want=1", in_ready);
    end
    // Start a frame, then assert reset mid-cycle: outputs drop immediately.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = SYNC;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (cpu_hold !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_rise got=%b want=1", cpu_hold);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, cpu_hold, mem_we} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL async_reset got=%b want=000", {in_ready, cpu_hold, mem_we});
    end
    @(negedge clk);
    rst = 1'b0;
    expDone = 1'b0;
    expErr = 1'b0;
    expHold = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL no_we_after_reset got=%b want=0", mem_we);
    end
  endtask

  task automatic test_good_frame();
    stim = '{8'h55, 8'hAA, 8'h4C, 8'h00, 8'h03, 8'hA0, 8'hB1, 8'hC2, 8'h13};
    modelStream();
    applyStimulus(0);
    total++;
    if (gotQ.size() != expQ.size()) begin
      bad++;
      $display("[TB] FAIL good_count got=%0d want=%0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        total++;
        if (gotQ[i] !== expQ[i] || gotCyc[i] != gotCyc[0] + i) begin
          bad++;
          $display("[TB] FAIL good_write%0d got=%h@%0d want=%h@%0d",
                   i, gotQ[i], gotCyc[i], expQ[i], gotCyc[0] + i);
        end
      end
    end
    total++;
    if ({load_done, load_err, cpu_hold} !== {expDone, expErr, expHold}) begin
      bad++;
      $display("[TB] FAIL good_status got=%b want=%b",
               {load_done, load_err, cpu_hold}, {expDone, expErr, expHold});
    end
    total++;
    if (!(lastWeCyc < holdFallCyc)) begin
      bad++;
      $display("[TB] FAIL hold_after_write got=we%0d/fall%0d want=we<fall",
               lastWeCyc, holdFallCyc);
    end
  endtask

  task automatic test_bad_checksum();
    stim = '{8'h4C, 8'h00, 8'h02, 8'h11, 8'h22, 8'h00};
    modelStream();
    applyStimulus(0);
    total++;
    if (gotQ.size() != expQ.size()) begin
      bad++;
      $display("[TB] FAIL badsum_count got=%0d want=%0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        total++;
        if (gotQ[i] !== expQ[i]) begin
          bad++;
          $display("[TB] FAIL badsum_write%0d got=%h want=%h", i, gotQ[i], expQ[i]);
        end
      end
    end
    total++;
    if ({load_done, load_err, cpu_hold} !== {expDone, expErr, expHold}) begin
      bad++;
      $display("[TB] FAIL badsum_status got=%b want=%b",
               {load_done, load_err, cpu_hold}, {expDone, expErr, expHold});
    end
  endtask

  task automatic test_len_errors();
    logic [7:0] lo;
    for (int t = 0; t < 2; t++) begin
      lo = (t == 0) ? 8'h00 : 8'h01;
      stim = '{8'h4C, (t == 0) ? 8'h00 : 8'h0E, lo};
      modelStream();
      applyStimulus(1);
      total++;
      if (gotQ.size() != 0 || {load_done, load_err, cpu_hold} !== {expDone, expErr, expHold}) begin
        bad++;
        $display("[TB] FAIL len_err%0d got=%0dw/%b want=0w/%b", t, gotQ.size(),
                 {load_done, load_err, cpu_hold}, {expDone, expErr, expHold});
      end
    end
  endtask

  task automatic test_max_frame();
    stim.delete();
    applyFrame(4096 - BASE, 1'b1, 1'b0);
    modelStream();
    applyStimulus(0);
    total++;
    if (gotQ.size() != expQ.size()) begin
      bad++;
      $display("[TB] FAIL max_count got=%0d want=%0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        total++;
        if (gotQ[i] !== expQ[i]) begin
          bad++;
          $display("[TB] FAIL max_write%0d got=%h want=%h", i, gotQ[i], expQ[i]);
        end
      end
      total++;
      if (gotQ[gotQ.size()-1][19:8] !== 12'hFFF) begin
        bad++;
        $display("[TB] FAIL max_last_addr got=%h want=fff", gotQ[gotQ.size()-1][19:8]);
      end
    end
    total++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL max_status got=%b want=100", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_gappy();
    for (int r = 0; r < 6; r++) begin
      stim = '{8'h55, 8'hAA};
      applyFrame(int'($urandom_range(40, 2)), 1'($urandom_range(1, 0)), 1'b1);
      modelStream();
      applyStimulus(3);
      total++;
      if (gotQ.size() != expQ.size()) begin
        bad++;
        $display("[TB] FAIL gappy%0d_count got=%0d want=%0d", r, gotQ.size(), expQ.size());
      end else begin
        for (int i = 0; i < expQ.size(); i++) begin
          total++;
          if (gotQ[i] !== expQ[i]) begin
            bad++;
            $display("[TB] FAIL gappy%0d_write%0d got=%h want=%h", r, i, gotQ[i], expQ[i]);
          end
        end
      end
      total++;
      if ({load_done, load_err, cpu_hold} !== {expDone, expErr, expHold}) begin
        bad++;
        $display("[TB] FAIL gappy%0d_status got=%b want=%b", r,
                 {load_done, load_err, cpu_hold}, {expDone, expErr, expHold});
      end
    end
  endtask

  task automatic test_reset_mid_data();
    stim = '{8'h4C, 8'h00, 8'h05, 8'h31, 8'h32};
    modelStream();
    applyStimulus(0);
    total++;
    if (gotQ.size() != expQ.size() || cpu_hold !== expHold) begin
      bad++;
      $display("[TB] FAIL partial got=%0dw/hold%b want=%0dw/hold%b",
               gotQ.size(), cpu_hold, expQ.size(), expHold);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({cpu_hold, load_done, load_err} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL midreset got=%b want=000", {cpu_hold, load_done, load_err});
    end
    @(negedge clk);
    rst = 1'b0;
    expDone = 1'b0;
    expErr = 1'b0;
    expHold = 1'b0;
    stim.delete();
    applyFrame(5, 1'b1, 1'b0);
    modelStream();
    applyStimulus(0);
    total++;
    if (gotQ.size() != expQ.size() || gotQ[0] !== expQ[0]) begin
      bad++;
      $display("[TB] FAIL reload got=%0dw first=%h want=%0dw first=%h",
               gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 20'hx, expQ.size(), expQ[0]);
    end
    total++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL reload_status got=%b want=100", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_back_to_back();
    stim.delete();
    applyFrame(4, 1'b0, 1'b0);
    applyFrame(6, 1'b1, 1'b1);
    modelStream();
    applyStimulus(0);
    total++;
    if (gotQ.size() != expQ.size()) begin
      bad++;
      $display("[TB] FAIL b2b_count got=%0d want=%0d", gotQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        total++;
        if (gotQ[i] !== expQ[i]) begin
          bad++;
          $display("[TB] FAIL b2b_write%0d got=%h want=%h", i, gotQ[i], expQ[i]);
        end
      end
    end
    total++;
    if ({load_done, load_err, cpu_hold} !== {expDone, expErr, expHold}) begin
      bad++;
      $display("[TB] FAIL b2b_status got=%b want=%b",
               {load_done, load_err, cpu_hold}, {expDone, expErr, expHold});
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_errors();
    test_max_frame();
    test_gappy();
    test_reset_mid_data();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
